// File: rtl/wb_regfile.sv
// wb_regfile: RV32I write-back result mux, 32x32 register file with write-through bypass, commit counter.
// Optional macro WB_RF_CLEAR_ON_RESET_EN: RST also clears the register array.
module wb_regfile #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RegWriteW,
  input  logic [2:0]        ResultSrcW,
  input  logic [XLEN-1:0]   ALUResultW,
  input  logic [XLEN-1:0]   ReadDataW,
  input  logic [ADDR_W-1:0] RdW,
  input  logic [XLEN-1:0]   ExtImmW,
  input  logic [XLEN-1:0]   PcTargetW,
  input  logic [XLEN-1:0]   PCPlus4W,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [XLEN-1:0]   RD1,
  output logic [XLEN-1:0]   RD2,
  output logic [XLEN-1:0]   ResultW,
  output logic [31:0]       WrCount
);
  logic [XLEN-1:0] regs [NREGS];
  logic [31:0]     wr_cnt;
  logic            wr_en;
  always_comb begin
    ResultW = ResultSrcW == 3'b000 ? ALUResultW :
              ResultSrcW == 3'b001 ? ReadDataW  :
              ResultSrcW == 3'b010 ? PCPlus4W   :
              ResultSrcW == 3'b011 ? ExtImmW    :
              ResultSrcW == 3'b100 ? PcTargetW  : '0;
    wr_en   = RegWriteW && RdW != '0;
    RD1     = A1 == '0 ? '0 : (wr_en && RdW == A1) ? ResultW : regs[A1];
    RD2     = A2 == '0 ? '0 : (wr_en && RdW == A2) ? ResultW : regs[A2];
  end
`ifdef WB_RF_CLEAR_ON_RESET_EN
  always_ff @(posedge CLK or posedge RST)
    if (RST)
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    else if (wr_en)
      regs[RdW] <= ResultW;
`else
  // No reset on the array; x0 stays unwritten and is masked on read.
  always_ff @(posedge CLK)
    if (wr_en && !RST)
      regs[RdW] <= ResultW;
`endif
  always_ff @(posedge CLK or posedge RST)
    if (RST)
      wr_cnt <= '0;
    else if (wr_en)
      wr_cnt <= wr_cnt + 32'd1;
  assign WrCount = wr_cnt;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed and randomized checks of wb_regfile against an array-based reference model.
module tb_wb_regfile;
  logic        CLK = 1'b0;
  logic        RST;
  logic        RegWriteW;
  logic [2:0]  ResultSrcW;
  logic [31:0] ALUResultW, ReadDataW, ExtImmW, PcTargetW, PCPlus4W;
  logic [4:0]  RdW, A1, A2;
  logic [31:0] RD1, RD2, ResultW, WrCount;
  int checks = 0;
  int errors = 0;
  logic [31:0] model [32];
  bit          valid [32];
  logic [31:0] exp_cnt;

  wb_regfile dut (
    .CLK(CLK), .RST(RST), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .RdW(RdW), .ExtImmW(ExtImmW),
    .PcTargetW(PcTargetW), .PCPlus4W(PCPlus4W), .A1(A1), .A2(A2),
    .RD1(RD1), .RD2(RD2), .ResultW(ResultW), .WrCount(WrCount)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] exp_result();
    logic [31:0] opts [8];
    opts = '{ALUResultW, ReadDataW, PCPlus4W, ExtImmW, PcTargetW, 32'd0, 32'd0, 32'd0};
    return opts[ResultSrcW];
  endfunction

  function automatic bit exp_known(input logic [4:0] a);
    return a == 0 || (RegWriteW && RdW != 0 && RdW == a) || valid[a];
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (RegWriteW && RdW != 0 && RdW == a) return exp_result();
    return model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) begin
`ifdef WB_RF_CLEAR_ON_RESET_EN
      model[i] = 32'd0;
      valid[i] = 1'b1;
`else
      valid[i] = (i == 0);
      model[i] = 32'd0;
`endif
    end
  endtask

  task automatic step();
    logic [31:0] r;
    r = exp_result();
    @(posedge CLK);
    if (RST) exp_cnt = 32'd0;
    else if (RegWriteW && RdW != 0) begin
      model[RdW] = r;
      valid[RdW] = 1'b1;
      exp_cnt = exp_cnt + 32'd1;
    end
    #1;
  endtask

  task automatic set_w(input logic we, input logic [2:0] src, input logic [4:0] rd, input logic [31:0] alu);
    RegWriteW = we; ResultSrcW = src; RdW = rd; ALUResultW = alu;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    set_w(1'b0, 3'd0, 5'd0, 32'd0);
    ReadDataW = 0; ExtImmW = 0; PcTargetW = 0; PCPlus4W = 0; A1 = 5'd5; A2 = 5'd0;
    exp_cnt = 0;
    clear_model();
    step();
    checks++;
    if (WrCount !== 32'd0) begin errors++; $display("FAIL reset_wrcount got %h want 0", WrCount); end
`ifdef WB_RF_CLEAR_ON_RESET_EN
    checks++;
    if (RD1 !== 32'd0) begin errors++; $display("FAIL reset_rd1 got %h want 0", RD1); end
`endif
    RST = 1'b0;
    #1;
  endtask

  task automatic test_bypass();
    set_w(1'b1, 3'b000, 5'd3, 32'h1234); A1 = 5'd3;
    #1;
    checks++;
    if (RD1 !== 32'h1234) begin errors++; $display("FAIL bypass_rd1 got %h want 00001234", RD1); end
    step();
    RegWriteW = 1'b0;
    #1;
    checks++;
    if (RD1 !== 32'h1234) begin errors++; $display("FAIL stored_rd1 got %h want 00001234", RD1); end
    checks++;
    if (WrCount !== 32'd1) begin errors++; $display("FAIL first_wrcount got %h want 1", WrCount); end
  endtask

  task automatic test_mux();
    logic [31:0] want [8];
    want = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd0, 32'd0};
    RegWriteW = 1'b0; ALUResultW = 1; ReadDataW = 2; PCPlus4W = 3; ExtImmW = 4; PcTargetW = 5;
    for (int s = 0; s < 8; s++) begin
      ResultSrcW = 3'(s);
      #1;
      checks++;
      if (ResultW !== want[s]) begin errors++; $display("FAIL mux_sel%0d got %h want %h", s, ResultW, want[s]); end
    end
  endtask

  task automatic test_x0();
    logic [31:0] c0;
    c0 = exp_cnt;
    set_w(1'b1, 3'b000, 5'd0, 32'hFFFFFFFF); A1 = 5'd0; A2 = 5'd0;
    #1;
    checks++;
    if (RD1 !== 32'd0 || RD2 !== 32'd0) begin errors++; $display("FAIL x0_bypass got %h/%h want 0", RD1, RD2); end
    step();
    RegWriteW = 1'b0;
    #1;
    checks++;
    if (RD1 !== 32'd0) begin errors++; $display("FAIL x0_stored got %h want 0", RD1); end
    checks++;
    if (WrCount !== c0) begin errors++; $display("FAIL x0_wrcount got %h want %h", WrCount, c0); end
  endtask

  task automatic test_dual();
    set_w(1'b1, 3'b000, 5'd7, 32'hA5A5A5A5); A1 = 5'd7; A2 = 5'd7;
    #1;
    checks++;
    if (RD1 !== 32'hA5A5A5A5 || RD2 !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL dual_bypass got %h/%h want a5a5a5a5", RD1, RD2);
    end
    step();
    set_w(1'b1, 3'b000, 5'd8, 32'h5A5A0001); A2 = 5'd8;
    #1;
    checks++;
    if (RD1 !== 32'hA5A5A5A5 || RD2 !== 32'h5A5A0001) begin
      errors++; $display("FAIL dual_x8 got %h/%h want a5a5a5a5/5a5a0001", RD1, RD2);
    end
    step();
    RegWriteW = 1'b0;
    #1;
    checks++;
    if (RD1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL dual_x7_kept got %h want a5a5a5a5", RD1); end
  endtask

  task automatic test_wrap();
    set_w(1'b1, 3'b000, 5'd1, 32'hCAFE0001);
    force dut.wr_cnt = 32'hFFFFFFFF;
    #1;
    release dut.wr_cnt;
    exp_cnt = 32'hFFFFFFFF;
    step();
    RegWriteW = 1'b0;
    #1;
    checks++;
    if (WrCount !== 32'd0) begin errors++; $display("FAIL wrap_wrcount got %h want 0", WrCount); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] want;
    set_w(1'b1, 3'b000, 5'd9, 32'h11110009); A1 = 5'd9;
    step();
    set_w(1'b1, 3'b000, 5'd9, 32'h22220009);
    #1;
    RST = 1'b1;
    #1;
    checks++;
    if (WrCount !== 32'd0) begin errors++; $display("FAIL rst_async_wrcount got %h want 0", WrCount); end
    clear_model();
    step();
    RST = 1'b0;
    RegWriteW = 1'b0;
    #1;
`ifdef WB_RF_CLEAR_ON_RESET_EN
    want = 32'd0;
`else
    want = 32'h11110009;
    model[9] = want; valid[9] = 1'b1;
`endif
    checks++;
    if (RD1 !== want) begin errors++; $display("FAIL rst_no_write got %h want %h", RD1, want); end
    set_w(1'b1, 3'b011, 5'd9, 32'd0); ExtImmW = 32'h33330009;
    step();
    RegWriteW = 1'b0;
    #1;
    checks++;
    if (RD1 !== 32'h33330009 || WrCount !== 32'd1) begin
      errors++; $display("FAIL post_rst_write got %h cnt %h want 33330009 cnt 1", RD1, WrCount);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      RegWriteW  = 1'($urandom_range(0, 3) != 0);
      ResultSrcW = 3'($urandom_range(0, 7));
      RdW        = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
      A1         = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
      A2         = 5'($urandom_range(0, 1) == 0 ? RdW : $urandom_range(0, 7));
      ALUResultW = $urandom; ReadDataW = $urandom; ExtImmW = $urandom;
      PcTargetW  = $urandom; PCPlus4W = $urandom;
      #1;
      checks++;
      if (ResultW !== exp_result()) begin errors++; $display("FAIL rnd_result n=%0d got %h want %h", n, ResultW, exp_result()); end
      if (exp_known(A1)) begin
        checks++;
        if (RD1 !== exp_read(A1)) begin errors++; $display("FAIL rnd_rd1 n=%0d a=%0d got %h want %h", n, A1, RD1, exp_read(A1)); end
      end
      if (exp_known(A2)) begin
        checks++;
        if (RD2 !== exp_read(A2)) begin errors++; $display("FAIL rnd_rd2 n=%0d a=%0d got %h want %h", n, A2, RD2, exp_read(A2)); end
      end
      step();
      checks++;
      if (WrCount !== exp_cnt) begin errors++; $display("FAIL rnd_wrcount n=%0d got %h want %h", n, WrCount, exp_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_mux();
    test_x0();
    test_dual();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
